// File: rtl/alu_result_buffer.sv
// Result buffer behind the 2-bit-opcode ALU: recomputes each result, derives
// {V,C,N,Z}, flags any disagreement, and queues entries for a stallable consumer.
module alu_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  logic [1:0]                     in_opcode,
  input  logic [WIDTH-1:0]               in_result,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_result,
  output logic [3:0]                     out_flags,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           mismatch
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Returns {V, r} where r is the (WIDTH+1)-bit recomputation; r[WIDTH] is the
  // carry for add and the borrow for sub, and is zero for the logic ops.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
    logic [WIDTH:0] r;
    logic           v;
    r = '0;
    v = 1'b0;
    case (op)
      2'b00: begin
        r = {1'b0, a} + {1'b0, b};
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        r = {1'b0, a} - {1'b0, b};
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10: r = {1'b0, a & b};
      2'b11: r = {1'b0, a | b};
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  logic [WIDTH-1:0] res_mem_q [DEPTH];
  logic [3:0]       flg_mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mismatch_q, mismatch_d;

  logic [WIDTH+1:0] eval;
  logic [WIDTH:0]   r;
  logic [3:0]       flags_new;
  logic             push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    eval      = alu_eval(in_a, in_b, in_opcode);
    r         = eval[WIDTH:0];
    flags_new = {eval[WIDTH+1], r[WIDTH], in_result[WIDTH-1], (in_result == '0)};
  end

  always_comb begin
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // Case inequality so an X on in_result is also reported as a mismatch.
    mismatch_d = mismatch_q || (push && (in_result !== r[WIDTH-1:0]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Entry storage needs no reset: out_valid gates what the consumer sees.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wptr_q] <= in_result;
      flg_mem_q[wptr_q] <= flags_new;
    end
  end

  assign out_result = out_valid ? res_mem_q[rptr_q] : '0;
  assign out_flags  = out_valid ? flg_mem_q[rptr_q] : '0;
  assign count      = count_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: flags, fill/drain, wrap-around
// streaming, sticky mismatch and asynchronous reset.
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b, in_result;
  logic [1:0] in_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [2:0] count;
  logic       mismatch;

  int vectors = 0;
  int miscompares = 0;

  alu_result_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .count(count), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] res);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    in_result = res;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++; if (mismatch !== 1'b0) begin miscompares++; $display("FAIL reset_mismatch got %b exp 0", mismatch); end
    vectors++; if ({out_result, out_flags} !== 12'h000) begin miscompares++; $display("FAIL reset_out_zero got %h/%b exp 00/0000", out_result, out_flags); end
    // pop attempt while empty must not underflow
    out_ready = 1'b1;
    step();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL empty_pop_count got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_add();
    drive(1'b1, 8'h7F, 8'h01, 2'b00, 8'h80);
    step();
    drive(1'b1, 8'hFF, 8'h01, 2'b00, 8'h00);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add1_valid got %b exp 1", out_valid); end
    vectors++; if (out_result !== 8'h80) begin miscompares++; $display("FAIL add1_result got %h exp 80", out_result); end
    vectors++; if (out_flags !== 4'b1010) begin miscompares++; $display("FAIL add1_flags got %b exp 1010", out_flags); end
    out_ready = 1'b1;
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL add_pushpop_count got %0d exp 1", count); end
    vectors++; if (out_result !== 8'h00) begin miscompares++; $display("FAIL add2_result got %h exp 00", out_result); end
    vectors++; if (out_flags !== 4'b0101) begin miscompares++; $display("FAIL add2_flags got %b exp 0101", out_flags); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain_valid got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_sub();
    drive(1'b1, 8'h03, 8'h05, 2'b01, 8'hFE);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    vectors++; if (out_flags !== 4'b0110) begin miscompares++; $display("FAIL sub1_flags got %b exp 0110", out_flags); end
    vectors++; if (out_result !== 8'hFE) begin miscompares++; $display("FAIL sub1_result got %h exp FE", out_result); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive(1'b1, 8'h05, 8'h05, 2'b01, 8'h00);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    vectors++; if (out_flags !== 4'b0001) begin miscompares++; $display("FAIL sub2_flags got %b exp 0001", out_flags); end
    vectors++; if (mismatch !== 1'b0) begin miscompares++; $display("FAIL sub_no_mismatch got %b exp 0", mismatch); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] vals [5];
    logic [2:0] exp_cnt;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vals[i], 8'hFF, 2'b10, vals[i]);
      step();
      exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
      vectors++; if (count !== exp_cnt) begin miscompares++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, exp_cnt); end
      vectors++; if (in_ready !== (i < 3)) begin miscompares++; $display("FAIL fill_in_ready[%0d] got %b exp %b", i, in_ready, (i < 3)); end
      vectors++; if (out_result !== 8'h11) begin miscompares++; $display("FAIL fill_head_hold[%0d] got %h exp 11", i, out_result); end
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_result !== vals[i]) begin miscompares++; $display("FAIL drain_result[%0d] got %h exp %h", i, out_result, vals[i]); end
      step();
      if (i == 0) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_in_ready got %b exp 1", in_ready); end
      end
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_count got %0d exp 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    logic [7:0] v;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v = 8'hA0 + 8'(i);
      drive(1'b1, v, 8'h00, 2'b11, v);
      q.push_back(v);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = 8'hB0 + 8'(i);
      drive(1'b1, v, 8'h00, 2'b11, v);
      vectors++; if (out_result !== q[0]) begin miscompares++; $display("FAIL wrap_order[%0d] got %h exp %h", i, out_result, q[0]); end
      void'(q.pop_front());
      q.push_back(v);
      step();
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d exp 2", i, count); end
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      vectors++; if (out_result !== q[0]) begin miscompares++; $display("FAIL wrap_tail[%0d] got %h exp %h", i, out_result, q[0]); end
      void'(q.pop_front());
      step();
    end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_mismatch_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h0F, 8'hF0, 2'b11, 8'h00);
    step();
    vectors++; if (mismatch !== 1'b1) begin miscompares++; $display("FAIL mismatch_set got %b exp 1", mismatch); end
    vectors++; if (out_flags !== 4'b0001) begin miscompares++; $display("FAIL mismatch_flags got %b exp 0001", out_flags); end
    drive(1'b1, 8'h01, 8'h01, 2'b00, 8'h02);
    step(); step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    vectors++; if (mismatch !== 1'b1) begin miscompares++; $display("FAIL mismatch_sticky got %b exp 1", mismatch); end
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL mismatch_count got %0d exp 3", count); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL async_rst_count got %0d exp 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid got %b exp 0", out_valid); end
    vectors++; if (mismatch !== 1'b0) begin miscompares++; $display("FAIL async_rst_mismatch got %b exp 0", mismatch); end
    step();
    rst = 1'b0;
    drive(1'b1, 8'h21, 8'h10, 2'b01, 8'h11);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL post_rst_count got %0d exp 1", count); end
    vectors++; if (out_result !== 8'h11) begin miscompares++; $display("FAIL post_rst_head got %h exp 11", out_result); end
    vectors++; if (out_flags !== 4'b0000) begin miscompares++; $display("FAIL post_rst_flags got %b exp 0000", out_flags); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_fill();
    test_back_to_back();
    test_mismatch_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 2-bit-opcode combinational ALU.
- Captures each ALU transaction (operands, opcode, result), derives status flags and cross-checks the result.
- Queues transactions in a small FIFO and presents them on a valid/ready output port to the writeback/consumer logic.
- Decouples the single-cycle ALU from a consumer that may stall.

Parameters:
WIDTH, 8, data width of operands and result
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  ALU transaction present
in_ready  output  1  buffer can accept
in_a  input  WIDTH  operand a given to the ALU
in_b  input  WIDTH  operand b given to the ALU
in_opcode  input  2  00 add, 01 sub, 10 and, 11 or
in_result  input  WIDTH  ALU result for this transaction
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_result  output  WIDTH  head result
out_flags  output  4  head flags {V,C,N,Z}
count  output  $clog2(DEPTH+1)  occupied entries
mismatch  output  1  sticky: an accepted in_result differed from the recomputed value

Behaviour:
- Reset (async, rst=1): count=0, out_valid=0, mismatch=0, read/write pointers=0. out_result and out_flags read 0 while empty.
- in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready.
- Push: in_valid && in_ready at a rising edge writes one entry at the write pointer.
- Pop: out_valid && out_ready at a rising edge removes the head.
- Push and pop in the same cycle leave count unchanged. Both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: an entry pushed into an empty buffer gives out_valid=1 the following cycle. There is no combinational bypass.
- out_result and out_flags are driven from the head entry. They hold stable while out_valid && !out_ready.
- Flag computation at push, using an internal (WIDTH+1)-bit computation r from in_a, in_b, in_opcode:
  - add: r = a + b. C = r[WIDTH]. V = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - sub: r = a - b. C = borrow (a < b, unsigned). V = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - and/or: r = a&b or a|b. C = 0. V = 0.
  - N = stored result[MSB]. Z = (stored result == 0).
- Stored result is in_result as received. Flags N and Z are derived from in_result. Flags C and V are derived from the recomputation.
- Mismatch: set when a push occurs and in_result != r[WIDTH-1:0], including when in_result contains X. It is cleared only by rst.
- Full: in_ready=0, in_valid ignored, no entry overwritten. A pop while full raises in_ready the next cycle.
- Empty: out_valid=0, out_ready ignored, count never underflows.
- rst asserted mid-operation discards all entries immediately. The first push after deassertion lands in entry 0.
- in_opcode is always a 2-bit value. No default or illegal encoding exists.

Test Plan:
- Reset then idle: rst pulse, in_valid=0 -> count=0, out_valid=0, in_ready=1, mismatch=0.
- Add with carry and overflow (WIDTH=8): a=8'h7F, b=8'h01, op=00, result=8'h80 -> next cycle out_valid=1, out_result=8'h80, flags {V,C,N,Z}=4'b1010. Then a=8'hFF, b=8'h01, result=8'h00 -> flags 4'b0101.
- Subtract borrow: a=8'h03, b=8'h05, op=01, result=8'hFE -> flags 4'b0110. a=8'h05, b=8'h05, result=8'h00 -> flags 4'b0001.
- Fill and backpressure: out_ready=0, push 5 transactions at DEPTH=4 -> count=4, in_ready=0 after the 4th, 5th not stored. Raise out_ready -> results drain in push order, count reaches 0, out_valid drops.
- Simultaneous push/pop at wrap: keep count=2, push and pop every cycle for 10 cycles -> count stays 2, output order matches input order across pointer wrap.
- Mismatch and reset: push a=8'h0F, b=8'hF0, op=11, result=8'h00 -> mismatch=1, stays 1 over further pushes. Assert rst with 3 entries queued -> count=0, out_valid=0, mismatch=0 immediately.
